// File: rtl/axi_sram_slave.sv
// AXI-lite-style SRAM responder with byte-strobe writes and a configurable read wait.
// One write and one read may be outstanding; the two paths are independent.
module axi_sram_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_WAIT   = 0,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic        s_rvalid,
    input  logic        s_rready
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN  = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACCESS, R_RESP} rd_state_t;

    logic [31:0]      mem [MEM_WORDS];

    logic             aw_held;
    logic             w_held;
    logic [31:0]      aw_addr_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic             aw_fire;
    logic             w_fire;
    logic             b_fire;
    logic             commit;
    logic [31:0]      wr_off;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_idx;

    rd_state_t        rd_state;
    logic [31:0]      rd_addr_q;
    logic [2:0]       wait_cnt;
    logic [31:0]      rd_off;
    logic             rd_hit;
    logic [IDX_W-1:0] rd_idx;

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    assign b_fire  = s_bvalid && s_bready;
    assign commit  = aw_held && w_held;

    assign wr_off  = aw_addr_q - BASE_ADDR;
    assign wr_hit  = {1'b0, wr_off} < SPAN;
    assign wr_idx  = wr_off[IDX_W+1:2];

    assign rd_off  = rd_addr_q - BASE_ADDR;
    assign rd_hit  = {1'b0, rd_off} < SPAN;
    assign rd_idx  = rd_off[IDX_W+1:2];

    // Write channel capture, commit and B handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            s_bvalid  <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
        end else if (commit) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_bvalid  <= 1'b1;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (b_fire) begin
                s_bvalid <= 1'b0;
            end
            // Readys track the next-cycle holding state so they stay registered
            s_awready <= !(aw_held || aw_fire) && !(s_bvalid && !s_bready);
            s_wready  <= !(w_held || w_fire) && !(s_bvalid && !s_bready);
        end
    end

    // SRAM array: lane-masked write at the commit edge, never reset
    always_ff @(posedge clk) begin
        if (rst_n && commit && wr_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb_q[i]) begin
                    mem[wr_idx][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

    // Read FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            rd_addr_q <= '0;
            wait_cnt  <= '0;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_arvalid && s_arready) begin
                        rd_addr_q <= s_araddr;
                        s_arready <= 1'b0;
                        if (RD_WAIT > 0) begin
                            rd_state <= R_WAIT;
                            wait_cnt <= 3'(RD_WAIT) - 3'd1;
                        end else begin
                            rd_state <= R_ACCESS;
                        end
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        rd_state <= R_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                R_ACCESS: begin
                    s_rdata  <= rd_hit ? mem[rd_idx] : ERR_DATA;
                    s_rvalid <= 1'b1;
                    rd_state <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                        rd_state  <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised self-checking bench for axi_sram_slave against a word-array reference model.
// Instance 0: base 0, no read wait. Instance 1: base 0x1000_0000, read wait 3.
module tb_axi_sram_slave;

    logic             clk;
    logic             rst_n;
    logic [1:0][31:0] awaddr, wdata, araddr, rdata;
    logic [1:0][3:0]  wstrb;
    logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]       arvalid, arready, rvalid, rready;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mdl [2][1024];

    axi_sram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .RD_WAIT(0), .ERR_DATA(32'hDEAD_BEEF)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(awaddr[0]), .s_awvalid(awvalid[0]), .s_awready(awready[0]),
        .s_wdata(wdata[0]), .s_wstrb(wstrb[0]), .s_wvalid(wvalid[0]), .s_wready(wready[0]),
        .s_bvalid(bvalid[0]), .s_bready(bready[0]),
        .s_araddr(araddr[0]), .s_arvalid(arvalid[0]), .s_arready(arready[0]),
        .s_rdata(rdata[0]), .s_rvalid(rvalid[0]), .s_rready(rready[0])
    );

    axi_sram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h1000_0000), .RD_WAIT(3), .ERR_DATA(32'hDEAD_BEEF)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(awaddr[1]), .s_awvalid(awvalid[1]), .s_awready(awready[1]),
        .s_wdata(wdata[1]), .s_wstrb(wstrb[1]), .s_wvalid(wvalid[1]), .s_wready(wready[1]),
        .s_bvalid(bvalid[1]), .s_bready(bready[1]),
        .s_araddr(araddr[1]), .s_arvalid(arvalid[1]), .s_arready(arready[1]),
        .s_rdata(rdata[1]), .s_rvalid(rvalid[1]), .s_rready(rready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h required %h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h1000_0000;
    endfunction

    function automatic int rdw_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit in_rng(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(d);
        return off < 32'd4096;
    endfunction

    function automatic int idx_of(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(d);
        return int'(off[11:2]);
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb);
        if (in_rng(d, a)) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mdl[d][idx_of(d, a)][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        return in_rng(d, a) ? mdl[d][idx_of(d, a)] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int cyc = 0;
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_go, w_go;
        awaddr[d] = a;
        wdata[d]  = data;
        wstrb[d]  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_dly) awvalid[d] = 1'b1;
            if (!w_done && cyc >= w_dly) wvalid[d] = 1'b1;
            aw_go = awvalid[d] && awready[d];
            w_go  = wvalid[d] && wready[d];
            tick();
            cyc++;
            if (aw_go) begin awvalid[d] = 1'b0; aw_done = 1'b1; end
            if (w_go) begin wvalid[d] = 1'b0; w_done = 1'b1; end
            if (w_done && !aw_done) begin
                chk("wready_after_w", 32'(wready[d]), 32'd0);
                chk("awready_while_w_held", 32'(awready[d]), 32'd1);
            end
            if (aw_done && !w_done) begin
                chk("awready_after_aw", 32'(awready[d]), 32'd0);
                chk("wready_while_aw_held", 32'(wready[d]), 32'd1);
            end
        end
        chk("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
        if (!(aw_done && w_done)) begin
            awvalid[d] = 1'b0;
            wvalid[d]  = 1'b0;
            return;
        end
        chk("bvalid_before_commit", 32'(bvalid[d]), 32'd0);
        tick();
        chk("bvalid_at_commit", 32'(bvalid[d]), 32'd1);
        model_write(d, a, data, strb);
        for (int i = 0; i < b_dly; i++) begin
            tick();
            chk("bvalid_hold", 32'(bvalid[d]), 32'd1);
            chk("awready_during_b", 32'(awready[d]), 32'd0);
            chk("wready_during_b", 32'(wready[d]), 32'd0);
        end
        bready[d] = 1'b1;
        tick();
        bready[d] = 1'b0;
        chk("bvalid_after_b", 32'(bvalid[d]), 32'd0);
        chk("awready_after_b", 32'(awready[d]), 32'd1);
        chk("wready_after_b", 32'(wready[d]), 32'd1);
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input int r_dly);
        int cyc = 0;
        logic [31:0] exp;
        exp = model_read(d, a);
        araddr[d]  = a;
        arvalid[d] = 1'b1;
        while (!arready[d] && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("ar_ready_seen", 32'(arready[d]), 32'd1);
        if (!arready[d]) begin
            arvalid[d] = 1'b0;
            return;
        end
        tick();
        arvalid[d] = 1'b0;
        for (int i = 0; i < rdw_of(d); i++) begin
            chk("rvalid_during_wait", 32'(rvalid[d]), 32'd0);
            chk("arready_during_wait", 32'(arready[d]), 32'd0);
            tick();
        end
        chk("rvalid_before_access", 32'(rvalid[d]), 32'd0);
        tick();
        chk("rvalid_latency", 32'(rvalid[d]), 32'd1);
        chk("rdata", rdata[d], exp);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            chk("rvalid_hold", 32'(rvalid[d]), 32'd1);
            chk("rdata_stable", rdata[d], exp);
            chk("arready_during_r", 32'(arready[d]), 32'd0);
        end
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
        chk("rvalid_after_r", 32'(rvalid[d]), 32'd0);
        chk("arready_after_r", 32'(arready[d]), 32'd1);
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_awready", 32'(awready[d]), 32'd0);
            chk("rst_wready", 32'(wready[d]), 32'd0);
            chk("rst_arready", 32'(arready[d]), 32'd0);
            chk("rst_bvalid", 32'(bvalid[d]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
        end
    endtask

    task automatic check_readys_up();
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_awready", 32'(awready[d]), 32'd1);
            chk("post_rst_wready", 32'(wready[d]), 32'd1);
            chk("post_rst_arready", 32'(arready[d]), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] a, old;
        rst_n   = 1'b0;
        awaddr  = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
        tick();
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        check_readys_up();

        // Known contents for the first 16 words of each instance
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_write(d, base_of(d) + 32'(i * 4), $urandom, 4'hF, 0, 0, 0);
            end
        end

        // Same-cycle AW/W then readback
        do_write(0, 32'h10, 32'hA5A5_1234, 4'hF, 0, 0, 0);
        do_read(0, 32'h10, 0);

        // Byte strobes
        do_write(0, 32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        chk("strobe_model", model_read(0, 32'h20), 32'h11BB_33DD);
        do_read(0, 32'h20, 1);

        // W leads AW by 3 cycles, B held off for 5 cycles
        do_write(0, 32'h24, 32'h0BAD_F00D, 4'hF, 3, 0, 5);
        do_read(0, 32'h24, 0);
        do_write(0, 32'h28, 32'h1357_9BDF, 4'b0000, 0, 2, 0);
        do_read(0, 32'h28, 0);

        // Read wait of 3 with 4 cycles of rready backpressure
        do_read(1, 32'h1000_0008, 4);

        // Out of range on the offset instance
        do_read(1, 32'h1000_1000, 0);
        do_write(1, 32'h1000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read(1, 32'h1000_0000, 0);
        do_read(0, 32'hFFFF_FFFC, 0);

        // Read access and write commit land on the same word in the same cycle
        a   = 32'h14;
        old = model_read(0, a);
        chk("coll_awready", 32'(awready[0]), 32'd1);
        chk("coll_arready", 32'(arready[0]), 32'd1);
        awaddr[0] = a; wdata[0] = ~old; wstrb[0] = 4'hF; araddr[0] = a;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
        chk("coll_bvalid_early", 32'(bvalid[0]), 32'd0);
        chk("coll_rvalid_early", 32'(rvalid[0]), 32'd0);
        tick();
        chk("coll_bvalid", 32'(bvalid[0]), 32'd1);
        chk("coll_rvalid", 32'(rvalid[0]), 32'd1);
        chk("coll_old_data", rdata[0], old);
        model_write(0, a, ~old, 4'hF);
        bready[0] = 1'b1; rready[0] = 1'b1;
        tick();
        bready[0] = 1'b0; rready[0] = 1'b0;
        chk("coll_bvalid_done", 32'(bvalid[0]), 32'd0);
        chk("coll_rvalid_done", 32'(rvalid[0]), 32'd0);
        do_read(0, a, 0);

        // Reset between AW and W drops the pending write
        a = 32'h18;
        awaddr[0] = a; awvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        chk("aw_held_awready", 32'(awready[0]), 32'd0);
        rst_n = 1'b0;
        wdata[0] = 32'hCAFE_0000; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
        tick();
        check_reset_outputs();
        wvalid[0] = 1'b0;
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        check_readys_up();
        do_write(0, 32'h1C, 32'h7777_8888, 4'hF, 0, 1, 0);
        do_read(0, a, 0);
        do_read(0, 32'h1C, 0);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            int d, idx;
            d   = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            a   = base_of(d) + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'd4096;
            if ($urandom_range(0, 1) == 0) begin
                do_write(d, a, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                do_read(d, a, int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Single-port AXI-lite-style responder that terminates the shared slave port driven by the 3-master interconnect.
- Uses the same reduced channel set as that port: AW, W, B, AR and R, with no ID and no response codes.
- Backs a word-addressed on-chip SRAM with byte-strobe writes and a configurable read wait.
- Accepts one outstanding write and one outstanding read; the read and write paths operate independently.

Parameters:
- MEM_WORDS, 1024: SRAM depth in 32-bit words; must be a power of two, at least 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to MEM_WORDS*4.
- RD_WAIT, 0: extra wait cycles inserted before read data is returned; range 0..7.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned for an out-of-range read.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- s_awaddr  in  32  write byte address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address accepted
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables; bit i enables byte lane i (bits 8i+7:8i)
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data accepted
- s_bvalid  out  1  write complete
- s_bready  in  1  write-complete accept
- s_araddr  in  32  read byte address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address accepted
- s_rdata  out  32  read data
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data accept

Behaviour:
- Reset:
  - While rst_n=0 at a clk edge, s_bvalid, s_rvalid, s_awready, s_wready and s_arready are 0, s_rdata is 0, and all holding flags and the read FSM are cleared.
  - All readys are 1 in the first cycle after rst_n rises.
  - SRAM contents are not reset.
- Address decode:
  - offset = addr - BASE_ADDR; in range iff offset < MEM_WORDS*4.
  - Word index = offset[log2(MEM_WORDS)+1:2]; addr[1:0] is ignored.
- Write capture:
  - AW and W are captured independently into holding registers (aw_held, w_held), in either order or in the same cycle.
  - s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid.
  - Handshake is valid&&ready at a clk edge.
- Write commit:
  - At the edge after both are held (edge N+1, where N is the edge that captured the later of the two), lanes with wstrb=1 are written if the address is in range.
  - At the same edge s_bvalid goes to 1 and aw_held and w_held are cleared.
  - An out-of-range write updates no memory but still completes with s_bvalid.
  - wstrb=4'b0000 writes nothing and still completes.
- B channel: s_bvalid holds until s_bready=1 at an edge. New AW/W are accepted from the cycle after B completes, so at most one write is outstanding.
- Read FSM states:
  - R_IDLE: s_arready=1. An AR handshake at edge N latches the address and moves to R_WAIT if RD_WAIT>0, else to R_ACCESS.
  - R_WAIT: counts RD_WAIT cycles, then moves to R_ACCESS.
  - R_ACCESS: SRAM read. At edge N+1+RD_WAIT, s_rdata is loaded (mem word, or ERR_DATA if out of range), s_rvalid goes to 1, and the FSM moves to R_RESP.
  - R_RESP: s_rdata/s_rvalid are held stable until s_rready=1 at an edge, then the FSM returns to R_IDLE and s_rvalid goes to 0.
- s_arready=0 in every state except R_IDLE. Back-to-back reads are therefore spaced at least 3+RD_WAIT cycles apart.
- Read/write collision: if the R_ACCESS read edge and a commit edge hit the same word, the read returns the old (pre-write) data. A read issued after s_bvalid is seen returns the new data.
- A reset mid-transaction drops all held and pending operations. A write whose commit edge has not yet occurred does not modify memory.
- s_rdata changes only at the R_ACCESS edge and at reset.

Test Plan:
- Write then read, RD_WAIT=0: AW 0x10 and W 0xA5A5_1234 with wstrb 4'hF in the same cycle. Required: s_bvalid 1 edge after the handshake. Then AR 0x10: s_rvalid 1 edge after the AR handshake with s_rdata=0xA5A5_1234.
- Byte strobes: word 0x20 holds 0x1122_3344; write 0xAABB_CCDD with wstrb 4'b0101. Required: readback 0x11BB_33DD.
- Channel ordering:
  - W is presented 3 cycles before AW. Required: s_wready drops after the W handshake, s_awready stays 1, and s_bvalid rises 1 edge after the AW handshake.
  - Hold s_bready=0 for 5 cycles. Required: s_bvalid stays 1 and s_awready=s_wready=0 throughout.
- RD_WAIT=3 with rready backpressure: AR handshake at edge N. Required: s_rvalid from edge N+4. With s_rready held 0 for 4 cycles, s_rdata stays stable and s_arready=0 until after R completes.
- Out of range, BASE_ADDR=0x1000_0000, MEM_WORDS=1024:
  - Read 0x1000_1000. Required: s_rdata=0xDEAD_BEEF.
  - Write 0x1000_1000. Required: completes with s_bvalid, and word 0 is unchanged.
- Collision and reset:
  - Read-access edge and write-commit edge on the same word in the same cycle. Required: the old value is returned.
  - Assert rst_n=0 after the AW handshake but before W. Required: all valids/readys are 0 during reset, memory is unchanged, and readys are 1 the cycle after release.
